dadder_dp_arb: RTL and testbench
================================

// Module: dadder_dp_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one Decimal adder/subtracter datapath among NUM_REQ requesters.
//  Accepts one BCD operation at a time, issues it to the adder and waits for vld_out.
//  Routes of_out/data_out back to the winning requester; aborts with an error if the adder stalls.
//  Sits between requester blocks and the adder's data plane input/output ports.
// PARAMETERS
//  NUM_REQ     4   number of requesters, 2..16
//  DATA_WIDTH  16  operand/result width in bits; multiple of 4 (BCD digits)
//  TIMEOUT     16  max WAIT cycles for vld_out before abort, >=2
// PORTS
//  clk        in   1                 clock, all logic on posedge
//  reset_n    in   1                 async active-low reset
//  req_vld    in   NUM_REQ           per-requester operation valid
//  req_rdy    out  NUM_REQ           per-requester accept; at most one bit set
//  req_op     in   NUM_REQ           per-requester op: 0=add, 1=subtract
//  req_a      in   NUM_REQ*DATA_WIDTH  operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_b      in   NUM_REQ*DATA_WIDTH  operand B, same packing
//  rsp_vld    out  NUM_REQ           one-hot 1-cycle response strobe, no backpressure
//  rsp_of     out  1                 overflow (add) / negative (sub) of result
//  rsp_err    out  1                 response is a timeout abort
//  rsp_data   out  DATA_WIDTH        result
//  vld_in     out  1                 to adder: operands valid (1-cycle pulse)
//  op_in      out  1                 to adder: op
//  a_in       out  DATA_WIDTH        to adder: operand A
//  b_in       out  DATA_WIDTH        to adder: operand B
//  vld_out    in   1                 from adder: result valid
//  of_out     in   1                 from adder: overflow/negative
//  data_out   in   DATA_WIDTH        from adder: result
//  busy       out  1                 state != IDLE
//  spur_err   out  1                 sticky: vld_out seen outside WAIT
//  err_clr    in   1                 clears spur_err (set wins if coincident)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; RR pointer = NUM_REQ-1 (requester 0 has first priority); latches 0.
//  Reset mid-operation: in-flight op dropped, no rsp_vld generated.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE.
//  IDLE:
//   - req_rdy combinational: one-hot to the first req_vld searching from ptr+1 upward, wrapping.
//   - Zero if none is valid.
//   - On edge with req_rdy[g]&req_vld[g]: latch op/a/b, ptr<=g, go ISSUE.
//  ISSUE: vld_in=1, op_in/a_in/b_in = latched values (held stable through WAIT); go WAIT; cnt<=0.
//  WAIT:
//   - vld_in=0.
//   - vld_out=1: capture of_out/data_out, err=0, go RESP.
//   - Else cnt++; when cnt==TIMEOUT-1 without vld_out: data=0, of=0, err=1, go RESP.
//   - vld_out on the final cycle wins over timeout.
//  RESP: rsp_vld[ptr]=1 with registered rsp_of/rsp_err/rsp_data for exactly one cycle; go IDLE.
//   - rsp_* are 0 when rsp_vld is 0.
//  Latency: accept at edge T -> vld_in high cycle T+1; adder vld_out at cycle T+1+L -> rsp_vld cycle T+2+L.
//  Min accept-to-accept spacing: 4 cycles.
//  req_vld deasserted/changed after accept: ignored (operands latched).
//  spur_err: set by vld_out in IDLE, ISSUE or RESP (incl. late result after timeout); cleared only by err_clr.
//  No arithmetic in block; operands pass unmodified; BCD validity is the requester's responsibility.
// TESTING
//  req_vld=0001, add a=0x0123 b=0x0456, model L=3 -> vld_in 1 cyc later; rsp_vld=0001, data=0x0579, of=0, err=0.
//  req_vld=1111 held, each deasserts after accept -> grant order 0,1,2,3; then req 0 and 2 together -> 0 then 2.
//  Sub a=0x0100 b=0x0250, model returns of_out=1 data=0x0150 -> rsp_vld[target], rsp_of=1, data=0x0150.
//  Model never responds, TIMEOUT=16 -> rsp_vld 16 WAIT cycles after ISSUE, err=1, data=0, busy falls next cycle.
//  vld_out pulse in IDLE -> spur_err=1 and stays set; err_clr pulse -> 0; no rsp_vld emitted.
//  reset_n low during WAIT -> all outputs 0 immediately, no rsp; vld_out after release -> spur_err=1.

Source files
------------

// File: rtl/dadder_dp_arb.sv
// dadder_dp_arb
//   Round-robin arbiter/sequencer sharing one decimal adder/subtracter among
//   NUM_REQ requesters. One operation is in flight at a time. The winner's
//   operands are latched and presented to the adder with a 1-cycle vld_in
//   pulse. The result, or a timeout abort if the adder stalls, is returned to
//   that winner as a 1-cycle response strobe.
//   No arithmetic is performed here: operands and results pass unmodified.

module dadder_dp_arb #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_vld,
   output logic [NUM_REQ-1:0]            req_rdy,
   input  logic [NUM_REQ-1:0]            req_op,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]            rsp_vld,
   output logic                          rsp_of,
   output logic                          rsp_err,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          vld_in,
   output logic                          op_in,
   output logic [DATA_WIDTH-1:0]         a_in,
   output logic [DATA_WIDTH-1:0]         b_in,
   input  logic                          vld_out,
   input  logic                          of_out,
   input  logic [DATA_WIDTH-1:0]         data_out,
   output logic                          busy,
   output logic                          spur_err,
   input  logic                          err_clr
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t              state;
   logic [PW-1:0]       ptr;        // last granted requester
   logic [CW-1:0]       cnt;        // WAIT cycles elapsed without vld_out

   logic [NUM_REQ-1:0]  grant;
   logic [PW-1:0]       grant_idx;
   logic [PW-1:0]       scan_idx;
   logic                found;

   logic                sel_op;
   logic [DATA_WIDTH-1:0] sel_a;
   logic [DATA_WIDTH-1:0] sel_b;

   // Round-robin search: first valid requester starting at ptr+1, wrapping.
   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      scan_idx  = '0;
      found     = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         scan_idx = PW'((int'(ptr) + i) % NUM_REQ);
         if (!found && req_vld[scan_idx]) begin
            found            = 1'b1;
            grant_idx        = scan_idx;
            grant[scan_idx]  = 1'b1;
         end
      end
   end

   // Operand mux for the candidate winner, indexed by constant loop slots.
   always_comb begin
      sel_op = 1'b0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == PW'(i)) begin
            sel_op = req_op[i];
            sel_a  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
            sel_b  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Accept strobe is only offered in IDLE, and is forced low while reset is
   // asserted so every output reads zero during reset.
   assign req_rdy = (state == IDLE && reset_n) ? grant : '0;

   // Sequencer: accept, issue, wait for the adder, respond.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         ptr      <= PW'(NUM_REQ - 1);
         cnt      <= '0;
         vld_in   <= 1'b0;
         op_in    <= 1'b0;
         a_in     <= '0;
         b_in     <= '0;
         rsp_vld  <= '0;
         rsp_of   <= 1'b0;
         rsp_err  <= 1'b0;
         rsp_data <= '0;
         busy     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  // Operands are captured here; later changes on the
                  // requester side have no effect on this operation.
                  op_in  <= sel_op;
                  a_in   <= sel_a;
                  b_in   <= sel_b;
                  ptr    <= grant_idx;
                  vld_in <= 1'b1;
                  busy   <= 1'b1;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               vld_in <= 1'b0;
               cnt    <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               if (vld_out) begin
                  // A result on the final WAIT cycle still beats the timeout.
                  rsp_vld[ptr] <= 1'b1;
                  rsp_of       <= of_out;
                  rsp_err      <= 1'b0;
                  rsp_data     <= data_out;
                  state        <= RESP;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  rsp_vld[ptr] <= 1'b1;
                  rsp_of       <= 1'b0;
                  rsp_err      <= 1'b1;
                  rsp_data     <= '0;
                  state        <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               rsp_vld  <= '0;
               rsp_of   <= 1'b0;
               rsp_err  <= 1'b0;
               rsp_data <= '0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky flag for adder results arriving when none is expected,
   // including a late result after a timeout. Set wins over clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spur_err <= 1'b0;
      end else if (vld_out && state != WAIT) begin
         spur_err <= 1'b1;
      end else if (err_clr) begin
         spur_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dadder_dp_arb.sv
// tb_dadder_dp_arb
//   Drives requesters and plays the adder. Expected grants come from a
//   round-robin model (last winner + scan), expected results from what the
//   bench's adder returned, expected timing from the cycle counts of the
//   issue/wait/respond sequence.

module tb_dadder_dp_arb;

   localparam int NUM_REQ = 4;
   localparam int DW      = 16;
   localparam int TIMEOUT = 16;
   localparam int IW      = $clog2(NUM_REQ);

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic [NUM_REQ-1:0]    req_vld;
   logic [NUM_REQ-1:0]    req_rdy;
   logic [NUM_REQ-1:0]    req_op;
   logic [NUM_REQ*DW-1:0] req_a;
   logic [NUM_REQ*DW-1:0] req_b;
   logic [NUM_REQ-1:0]    rsp_vld;
   logic                  rsp_of;
   logic                  rsp_err;
   logic [DW-1:0]         rsp_data;
   logic                  vld_in;
   logic                  op_in;
   logic [DW-1:0]         a_in;
   logic [DW-1:0]         b_in;
   logic                  vld_out = 1'b0;
   logic                  of_out = 1'b0;
   logic [DW-1:0]         data_out = '0;
   logic                  busy;
   logic                  spur_err;
   logic                  err_clr = 1'b0;

   // Requester-side state, packed onto the DUT buses below.
   logic                  slot_vld [NUM_REQ];
   logic                  slot_op  [NUM_REQ];
   logic [DW-1:0]         slot_a   [NUM_REQ];
   logic [DW-1:0]         slot_b   [NUM_REQ];

   int                    vectors = 0;
   int                    miscompares = 0;
   int                    last_grant = NUM_REQ - 1;
   logic                  exp_spur = 1'b0;

   always #5 clk = ~clk;

   always_comb begin
      req_vld = '0;
      req_op  = '0;
      req_a   = '0;
      req_b   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_vld[i]           = slot_vld[i];
         req_op[i]            = slot_op[i];
         req_a[i*DW +: DW]    = slot_a[i];
         req_b[i*DW +: DW]    = slot_b[i];
      end
   end

   dadder_dp_arb #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req_vld  (req_vld),
      .req_rdy  (req_rdy),
      .req_op   (req_op),
      .req_a    (req_a),
      .req_b    (req_b),
      .rsp_vld  (rsp_vld),
      .rsp_of   (rsp_of),
      .rsp_err  (rsp_err),
      .rsp_data (rsp_data),
      .vld_in   (vld_in),
      .op_in    (op_in),
      .a_in     (a_in),
      .b_in     (b_in),
      .vld_out  (vld_out),
      .of_out   (of_out),
      .data_out (data_out),
      .busy     (busy),
      .spur_err (spur_err),
      .err_clr  (err_clr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Round-robin reference: first valid requester after the last winner.
   function automatic int exp_winner();
      int k;
      for (int i = 1; i <= NUM_REQ; i++) begin
         k = (last_grant + i) % NUM_REQ;
         if (slot_vld[IW'(k)]) return k;
      end
      return -1;
   endfunction

   // Called at a negedge; returns at the negedge after reset is released.
   task automatic do_reset(input string tag);
      reset_n  = 1'b0;
      vld_out  = 1'b0;
      of_out   = 1'b0;
      data_out = '0;
      err_clr  = 1'b0;
      slot_vld = '{default: 1'b0};
      #1;
      check(tag, 64'({rsp_vld, rsp_of, rsp_err, rsp_data, vld_in, op_in,
                      a_in, b_in, busy, spur_err, req_rdy}), 64'd0);
      @(negedge clk);
      reset_n    = 1'b1;
      last_grant = NUM_REQ - 1;
      exp_spur   = 1'b0;
   endtask

   // One operation: accept, issue, adder answers on WAIT cycle 'lat'
   // (lat < 1 means never). Called and returns at a negedge in IDLE.
   task automatic do_op(input int lat, input logic [DW-1:0] rdata, input logic rof);
      int            w;
      int            n;
      int            n_exp;
      bit            seen;
      bit            timed_out;
      logic [DW-1:0] ea;
      logic [DW-1:0] eb;
      logic          eop;
      #1;
      w = exp_winner();
      check("req_rdy", 64'(req_rdy), (w < 0) ? 64'd0 : (64'd1 << w));
      if (w < 0) return;
      ea  = slot_a[IW'(w)];
      eb  = slot_b[IW'(w)];
      eop = slot_op[IW'(w)];
      @(negedge clk);
      last_grant = w;
      check("vld_in_issue", 64'(vld_in), 64'd1);
      check("busy_issue", 64'(busy), 64'd1);
      check("rdy_busy", 64'(req_rdy), 64'd0);
      check("op_in", 64'(op_in), 64'(eop));
      check("a_in", 64'(a_in), 64'(ea));
      check("b_in", 64'(b_in), 64'(eb));
      // Winner drops its request and scribbles its operands.
      slot_vld[IW'(w)] = 1'b0;
      slot_a[IW'(w)]   = DW'($urandom);
      slot_b[IW'(w)]   = DW'($urandom);
      slot_op[IW'(w)]  = 1'($urandom);
      timed_out = (lat < 1) || (lat > TIMEOUT);
      n_exp     = timed_out ? TIMEOUT + 1 : lat + 1;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         seen = (rsp_vld != '0);
         if (n == 1) begin
            check("vld_in_pulse", 64'(vld_in), 64'd0);
            check("a_in_hold", 64'(a_in), 64'(ea));
         end
         vld_out  = (n == lat);
         of_out   = (n == lat) ? rof : 1'($urandom);
         data_out = (n == lat) ? rdata : DW'($urandom);
      end
      check("rsp_cycle", 64'(n), 64'(n_exp));
      check("rsp_vld", 64'(rsp_vld), 64'd1 << w);
      check("rsp_err", 64'(rsp_err), 64'(timed_out));
      check("rsp_of", 64'(rsp_of), timed_out ? 64'd0 : 64'(rof));
      check("rsp_data", 64'(rsp_data), timed_out ? 64'd0 : 64'(rdata));
      check("busy_resp", 64'(busy), 64'd1);
      if (lat == TIMEOUT + 1) exp_spur = 1'b1;
      @(negedge clk);
      vld_out  = 1'b0;
      of_out   = 1'b0;
      data_out = '0;
      check("rsp_idle", 64'({rsp_vld, rsp_of, rsp_err, rsp_data}), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);
      check("spur_after_op", 64'(spur_err), 64'(exp_spur));
   endtask

   // Adder model: plain binary add/sub with carry/borrow as the flag.
   task automatic model_op(input int lat);
      int          w;
      logic [DW:0] s;
      w = exp_winner();
      s = '0;
      if (w >= 0) begin
         if (slot_op[IW'(w)])
            s = {1'b0, slot_a[IW'(w)]} - {1'b0, slot_b[IW'(w)]};
         else
            s = {1'b0, slot_a[IW'(w)]} + {1'b0, slot_b[IW'(w)]};
      end
      do_op(lat, s[DW-1:0], s[DW]);
   endtask

   task automatic clear_spur();
      logic saved [NUM_REQ];
      saved    = slot_vld;
      slot_vld = '{default: 1'b0};
      err_clr  = 1'b1;
      @(negedge clk);
      err_clr  = 1'b0;
      check("spur_clr", 64'(spur_err), 64'd0);
      exp_spur = 1'b0;
      slot_vld = saved;
   endtask

   task automatic set_slot(input int i, input logic op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
      slot_vld[IW'(i)] = 1'b1;
      slot_op[IW'(i)]  = op;
      slot_a[IW'(i)]   = a;
      slot_b[IW'(i)]   = b;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int lat;
      slot_vld = '{default: 1'b0};
      slot_op  = '{default: 1'b0};
      slot_a   = '{default: '0};
      slot_b   = '{default: '0};

      @(negedge clk);
      do_reset("rst_init");

      // Single add on requester 0, adder latency 3.
      set_slot(0, 1'b0, 16'h0123, 16'h0456);
      do_op(3, 16'h0579, 1'b0);

      // All four requesting from reset: order 0,1,2,3; then 0 and 2 together.
      do_reset("rst_rr");
      for (int i = 0; i < NUM_REQ; i++)
         set_slot(i, 1'($urandom), DW'($urandom), DW'($urandom));
      for (int i = 0; i < NUM_REQ; i++) begin
         check("rr_order", 64'(exp_winner()), 64'(i));
         model_op($urandom_range(1, 4));
      end
      set_slot(0, 1'b0, 16'h1111, 16'h2222);
      set_slot(2, 1'b1, 16'h3333, 16'h0444);
      model_op(1);
      model_op(2);

      // Subtract returning negative flag.
      set_slot(1, 1'b1, 16'h0100, 16'h0250);
      do_op(2, 16'h0150, 1'b1);

      // Adder never answers: timeout abort.
      set_slot(3, 1'b0, 16'h9999, 16'h0001);
      do_op(-1, '0, 1'b0);

      // Answer on the final WAIT cycle beats the timeout.
      set_slot(0, 1'b0, 16'h0042, 16'h0017);
      model_op(TIMEOUT);

      // Answer one cycle too late: abort, then the late pulse is spurious.
      set_slot(2, 1'b1, 16'h0500, 16'h0250);
      model_op(TIMEOUT + 1);
      clear_spur();

      // Spurious vld_out in IDLE; sticky; set wins over clear.
      vld_out  = 1'b1;
      data_out = 16'hdead;
      @(negedge clk);
      vld_out  = 1'b0;
      check("spur_idle", 64'(spur_err), 64'd1);
      check("spur_no_rsp", 64'(rsp_vld), 64'd0);
      repeat (3) @(negedge clk);
      check("spur_sticky", 64'(spur_err), 64'd1);
      vld_out = 1'b1;
      err_clr = 1'b1;
      @(negedge clk);
      vld_out = 1'b0;
      err_clr = 1'b0;
      check("spur_set_wins", 64'(spur_err), 64'd1);
      exp_spur = 1'b1;
      clear_spur();

      // Reset while waiting on the adder.
      set_slot(2, 1'b1, 16'h4321, 16'h8765);
      #1;
      check("rdy_pre_rst", 64'(req_rdy), 64'd1 << exp_winner());
      @(negedge clk);
      slot_vld[2] = 1'b0;
      check("vld_in_pre_rst", 64'(vld_in), 64'd1);
      repeat (3) @(negedge clk);
      check("busy_pre_rst", 64'(busy), 64'd1);
      do_reset("rst_mid_wait");
      repeat (3) begin
         @(negedge clk);
         check("no_rsp_after_rst", 64'({rsp_vld, busy}), 64'd0);
      end
      vld_out  = 1'b1;
      data_out = 16'h1234;
      @(negedge clk);
      vld_out  = 1'b0;
      data_out = '0;
      check("spur_after_rst", 64'(spur_err), 64'd1);
      check("no_rsp_late", 64'(rsp_vld), 64'd0);
      exp_spur = 1'b1;
      clear_spur();

      // Randomized traffic.
      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!slot_vld[IW'(i)] && $urandom_range(0, 2) == 0)
               set_slot(i, 1'($urandom), DW'($urandom), DW'($urandom));
         end
         if (exp_winner() < 0)
            set_slot($urandom_range(0, NUM_REQ - 1), 1'($urandom), DW'($urandom), DW'($urandom));
         r = $urandom_range(0, 11);
         if (r == 0)      lat = -1;
         else if (r == 1) lat = TIMEOUT + 1;
         else if (r == 2) lat = TIMEOUT;
         else             lat = $urandom_range(1, 5);
         model_op(lat);
         if (exp_spur) clear_spur();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
